// File: rtl/power_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : power_sequencer
//  Purpose  : Power-up/power-down sequencer for the bubble-memory emulator.
//             Synchronises power_good and holds READY low for a settle time.
//             It then captures the boot image number from the DIP switches
//             and releases the bubble interface. On a power drop it returns
//             to not-ready and re-runs the full sequence on repower.
//  Revision : 1.0  initial release
// ============================================================================
module power_sequencer #(
  parameter int SYNC_STAGES      = 3,
  parameter int NOT_READY_CYCLES = 1024,
  parameter int LATCH_CYCLES     = 1024,
  parameter int IMAGE_BITS       = 3,
  parameter bit LATCH_ONCE       = 1'b0,
  parameter int FAIL_CNT_BITS    = 8
) (
  input  logic                     master_clock,
  input  logic                     reset_n,
  input  logic                     power_good,
  input  logic [IMAGE_BITS-1:0]    image_dip_switch,
  output logic                     temperature_low,
  output logic                     bubble_module_enable,
  output logic [IMAGE_BITS-1:0]    image_number,
  output logic                     image_valid,
  output logic [FAIL_CNT_BITS-1:0] power_fail_count,
  output logic [1:0]               seq_state
);

  // One counter serves both timed phases, so it is sized for the longer one.
  localparam int MAX_CYCLES = (NOT_READY_CYCLES > LATCH_CYCLES) ? NOT_READY_CYCLES : LATCH_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0]         WAIT_LAST  = CNT_W'(NOT_READY_CYCLES - 1);
  localparam logic [CNT_W-1:0]         LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
  localparam logic [FAIL_CNT_BITS-1:0] FAIL_ONE   = FAIL_CNT_BITS'(1);
  localparam logic [FAIL_CNT_BITS-1:0] FAIL_MAX   = {FAIL_CNT_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_LATCH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Registered state
  logic [SYNC_STAGES-1:0]   pg_sync_q,  pg_sync_d;
  logic [IMAGE_BITS-1:0]    dip_meta_q, dip_meta_d;
  logic [IMAGE_BITS-1:0]    dip_s_q,    dip_s_d;
  state_t                   state_q,    state_d;
  logic [CNT_W-1:0]         cnt_q,      cnt_d;
  logic [IMAGE_BITS-1:0]    image_q,    image_d;
  logic                     valid_q,    valid_d;
  logic [FAIL_CNT_BITS-1:0] fail_q,     fail_d;
  logic                     ready_q,    ready_d;
  logic                     enable_n_q, enable_n_d;

  logic power_ok;
  logic capture_en;

  assign power_ok = pg_sync_q[SYNC_STAGES-1];

  // In capture-once mode the first successful capture is kept until reset.
  assign capture_en = !LATCH_ONCE || !valid_q;

  // Next-state logic for the synchronisers, sequencer and its registered outputs.
  always_comb begin
    pg_sync_d  = {pg_sync_q[SYNC_STAGES-2:0], power_good};
    dip_meta_d = image_dip_switch;
    dip_s_d    = dip_meta_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    image_d = image_q;
    valid_d = valid_q;
    fail_d  = fail_q;

    case (state_q)
      ST_OFF: begin
        if (power_ok) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!power_ok) begin
          state_d = ST_OFF;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LATCH: begin
        if (!power_ok) begin
          state_d = ST_OFF;
        end else if (cnt_q == LATCH_LAST) begin
          state_d = ST_RUN;
          // Switches are active-low, so the image number is the inverse.
          if (capture_en) begin
            image_d = ~dip_s_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!power_ok) begin
          state_d = ST_OFF;
          if (fail_q != FAIL_MAX) begin
            fail_d = fail_q + FAIL_ONE;
          end
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Capture-every-boot mode forgets the image whenever power is lost.
    if (!LATCH_ONCE && (state_d == ST_OFF) && (state_q != ST_OFF)) begin
      valid_d = 1'b0;
    end

    // Host handshakes follow the next state so they change on the same edge.
    ready_d    = (state_d == ST_RUN);
    enable_n_d = (state_d != ST_RUN);
  end

  // All flops, cleared asynchronously to the safe not-ready condition.
  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      pg_sync_q  <= '0;
      dip_meta_q <= '0;
      dip_s_q    <= '0;
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      image_q    <= '0;
      valid_q    <= 1'b0;
      fail_q     <= '0;
      ready_q    <= 1'b0;
      enable_n_q <= 1'b1;
    end else begin
      pg_sync_q  <= pg_sync_d;
      dip_meta_q <= dip_meta_d;
      dip_s_q    <= dip_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      image_q    <= image_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
      ready_q    <= ready_d;
      enable_n_q <= enable_n_d;
    end
  end

  assign temperature_low      = ready_q;
  assign bubble_module_enable = enable_n_q;
  assign image_number         = image_q;
  assign image_valid          = valid_q;
  assign power_fail_count     = fail_q;
  assign seq_state            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_power_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_power_sequencer
//  Purpose  : Self-checking bench for power_sequencer. Two instances (capture
//             every boot / capture once) share the same stimulus and are
//             compared each cycle against a timeline-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_power_sequencer;

  localparam int S  = 3;
  localparam int N  = 8;
  localparam int L  = 4;
  localparam int IB = 3;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pg_in;
  logic [IB-1:0] dip_in;

  logic [1:0]    tl, en, vld;
  logic [IB-1:0] num [2];
  logic [FB-1:0] fc  [2];
  logic [1:0]    st  [2];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  power_sequencer #(
    .SYNC_STAGES(S), .NOT_READY_CYCLES(N), .LATCH_CYCLES(L),
    .IMAGE_BITS(IB), .LATCH_ONCE(1'b0), .FAIL_CNT_BITS(FB)
  ) u_every (
    .master_clock(clk), .reset_n(rst_n), .power_good(pg_in),
    .image_dip_switch(dip_in), .temperature_low(tl[0]),
    .bubble_module_enable(en[0]), .image_number(num[0]),
    .image_valid(vld[0]), .power_fail_count(fc[0]), .seq_state(st[0])
  );

  power_sequencer #(
    .SYNC_STAGES(S), .NOT_READY_CYCLES(N), .LATCH_CYCLES(L),
    .IMAGE_BITS(IB), .LATCH_ONCE(1'b1), .FAIL_CNT_BITS(FB)
  ) u_once (
    .master_clock(clk), .reset_n(rst_n), .power_good(pg_in),
    .image_dip_switch(dip_in), .temperature_low(tl[1]),
    .bubble_module_enable(en[1]), .image_number(num[1]),
    .image_valid(vld[1]), .power_fail_count(fc[1]), .seq_state(st[1])
  );

  // ---------------- reference model ----------------
  // The sequencer position is derived from how many consecutive edges the
  // delayed power_good has been seen high: 1..N WAIT, N+1..N+L LATCH, then RUN.
  int            pg_hist[$];
  logic [IB-1:0] dip_hist[$];
  int            k_up;
  int            m_fails;
  logic [IB-1:0] m_num [2];
  bit            m_valid [2];

  function automatic int st_of(input int kk);
    if (kk == 0)          return 0;
    else if (kk <= N)     return 1;
    else if (kk <= N + L) return 2;
    else                  return 3;
  endfunction

  task automatic model_reset();
    pg_hist.delete();
    dip_hist.delete();
    for (int i = 0; i < S; i++) pg_hist.push_back(0);
    for (int i = 0; i < 2; i++) dip_hist.push_back('0);
    k_up    = 0;
    m_fails = 0;
    for (int i = 0; i < 2; i++) begin
      m_num[i]   = '0;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic pg, input logic [IB-1:0] dip);
    int pok;
    int ps;
    int ns;
    logic [IB-1:0] dold;
    pok  = pg_hist.pop_front();
    pg_hist.push_back(int'(pg));
    dold = dip_hist.pop_front();
    dip_hist.push_back(dip);
    ps = st_of(k_up);
    if (pok != 0) begin
      if (k_up < N + L + 1) k_up++;
    end else begin
      k_up = 0;
    end
    ns = st_of(k_up);
    if (ps == 3 && ns == 0 && m_fails < (1 << FB) - 1) m_fails++;
    if (ps == 2 && ns == 3) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0 || !m_valid[i]) begin
          m_num[i]   = ~dold;
          m_valid[i] = 1'b1;
        end
      end
    end
    if (ps != 0 && ns == 0) m_valid[0] = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int ms;
    ms = st_of(k_up);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("seq_state%0d", i), 32'(st[i]),  32'(ms));
      chk($sformatf("temp_low%0d", i),  32'(tl[i]),  32'(ms == 3));
      chk($sformatf("enable_n%0d", i),  32'(en[i]),  32'(ms != 3));
      chk($sformatf("img_num%0d", i),   32'(num[i]), 32'(m_num[i]));
      chk($sformatf("img_vld%0d", i),   32'(vld[i]), 32'(m_valid[i]));
      chk($sformatf("fail_cnt%0d", i),  32'(fc[i]),  32'(m_fails));
    end
  endtask

  // Called at a falling edge; applies inputs for the next rising edge.
  task automatic step(input logic pg, input logic [IB-1:0] dip);
    pg_in  = pg;
    dip_in = dip;
    @(posedge clk);
    if (rst_n) model_edge(pg, dip);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int first;

  initial begin
    rst_n  = 1'b0;
    pg_in  = 1'b0;
    dip_in = 3'b101;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 3'b101);

    // Nominal boot: READY at edge S+N+L.
    first = -1;
    for (int e = 0; e < 20; e++) begin
      step(1'b1, 3'b101);
      if (tl[0] && first < 0) first = e;
    end
    chk("boot_edge", 32'(first), 32'd15);
    chk("boot_img", 32'(num[0]), 32'(3'b010));
    chk("boot_vld", 32'(vld[0]), 32'd1);

    // Brown-out in RUN: READY drops S edges after power_good.
    first = -1;
    for (int e = 0; e < 6; e++) begin
      step(1'b0, 3'b101);
      if (!tl[0] && first < 0) first = e;
    end
    chk("drop_edge", 32'(first), 32'd3);
    chk("drop_cnt", 32'(fc[0]), 32'd1);
    first = -1;
    for (int e = 0; e < 20; e++) begin
      step(1'b1, 3'b101);
      if (tl[0] && first < 0) first = e;
    end
    chk("reboot_edge", 32'(first), 32'd15);

    // Abort during WAIT: drop at edge 6, return at edge 20.
    for (int e = 0; e < 6; e++) step(1'b0, 3'b101);
    first = -1;
    for (int e = 0; e < 40; e++) begin
      step((e < 6 || e >= 20) ? 1'b1 : 1'b0, 3'b101);
      if (tl[0] && first < 0) first = e;
    end
    chk("abort_edge", 32'(first), 32'd35);
    chk("abort_cnt", 32'(fc[0]), 32'd2);

    // Capture-once versus capture-every-boot.
    for (int e = 0; e < 6; e++) step(1'b0, 3'b110);
    apply_reset();
    for (int e = 0; e < 20; e++) step(1'b1, 3'b110);
    for (int e = 0; e < 6; e++) step(1'b0, 3'b000);
    chk("off_vld_every", 32'(vld[0]), 32'd0);
    chk("off_vld_once", 32'(vld[1]), 32'd1);
    for (int e = 0; e < 20; e++) step(1'b1, 3'b000);
    chk("once_img", 32'(num[1]), 32'(3'b001));
    chk("every_img", 32'(num[0]), 32'(3'b111));

    // Reset while in LATCH.
    for (int e = 0; e < 6; e++) step(1'b0, 3'b011);
    for (int e = 0; e < S + N + 2; e++) step(1'b1, 3'b011);
    chk("in_latch", 32'(st[0]), 32'd2);
    apply_reset();

    // Saturation of the power-fail counter.
    for (int b = 0; b < 300; b++) begin
      for (int e = 0; e < S + N + L + 2; e++) step(1'b1, 3'b010);
      for (int e = 0; e < S + 2; e++) step(1'b0, 3'b010);
    end
    chk("sat_cnt", 32'(fc[0]), 32'd255);
    apply_reset();

    // Randomised power sequences, DIP changes and occasional resets.
    begin
      logic          r_pg;
      logic [IB-1:0] r_dip;
      int            hold;
      r_pg  = 1'b0;
      r_dip = IB'($urandom);
      hold  = 0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          r_pg = ~r_pg;
          hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 30);
        end
        hold--;
        if ($urandom_range(0, 7) == 0) r_dip = IB'($urandom);
        if ($urandom_range(0, 199) == 0) apply_reset();
        step(r_pg, r_dip);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
